// File: rtl/antilog_unpack_pip.sv
// antilog_unpack_pip
// Converts a packed vector of Q_ORD log-domain terms back to linear signed
// fixed point. A vector is captured on one handshake, its terms are issued
// one per cycle into a two-stage antilog pipeline, and the linear results
// stream out back-to-back with a term index and a last flag.
//
// Ports
//   clk              clock, all state on rising edge
//   reset            asynchronous active-low reset
//   in_valid         packed vector offered
//   in_ready         block can accept a vector (high in IDLE)
//   log_in_packed    term k log word at [k*LOG_WIDTH +: LOG_WIDTH]
//   sign_in_packed   term k sign (1 = negative)
//   valid_in_packed  term k valid (0 = value is exactly zero)
//   out_valid        out_data holds a converted term (no backpressure)
//   out_data         signed linear value, QP fractional bits
//   out_idx          term index of out_data
//   out_last         out_data is term Q_ORD-1
//   busy             FSM not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a vector, in_ready=1
// ISSUE | one held term per cycle enters stage 1
// DRAIN | last term in flight; back to IDLE when out_last registers
module antilog_unpack_pip #(
  parameter int Q_ORD      = 3,
  parameter int WIDTH      = 16,
  parameter int QP         = 12,
  parameter int LOG_WIDTH  = 17,
  parameter int FRAC_WIDTH = 12,
  localparam int IW        = (Q_ORD > 1) ? $clog2(Q_ORD) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Q_ORD*LOG_WIDTH-1:0] log_in_packed,
  input  logic [Q_ORD-1:0]           sign_in_packed,
  input  logic [Q_ORD-1:0]           valid_in_packed,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [IW-1:0]              out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int EW  = LOG_WIDTH - FRAC_WIDTH;
  localparam int QW  = $clog2(QP + 1);
  // Shift width holds the full signed exponent range offset by QP.
  localparam int SW  = ((EW > QW) ? EW : QW) + 2;
  localparam int PW  = FRAC_WIDTH + WIDTH + 1;
  localparam logic [IW-1:0]          LAST_IDX  = IW'(Q_ORD - 1);
  localparam logic signed [SW-1:0]   SAT_SHIFT = SW'(WIDTH - 1);
  localparam logic signed [SW-1:0]   QP_S      = SW'(QP);
  localparam logic [WIDTH-1:0]       MAX_MAG   = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state;
  logic [IW-1:0]              counter;
  logic [Q_ORD*LOG_WIDTH-1:0] log_hold;
  logic [Q_ORD-1:0]           sign_hold;
  logic [Q_ORD-1:0]           valid_hold;

  logic                       s1_valid;
  logic signed [SW-1:0]       s1_shift;
  logic [FRAC_WIDTH:0]        s1_m;
  logic                       s1_sign;
  logic                       s1_sat;
  logic                       s1_zero;
  logic [IW-1:0]              s1_idx;
  logic                       s1_last;

  logic [LOG_WIDTH-1:0]       term_log;
  logic                       term_sign;
  logic                       term_valid;
  logic signed [EW-1:0]       e_c;
  logic signed [SW-1:0]       shift_c;
  logic                       sat_c;
  logic                       zero_c;
  logic [SW-1:0]              sh_u;
  logic [WIDTH-1:0]           mag_c;
  logic [WIDTH-1:0]           data_c;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      log_hold   <= '0;
      sign_hold  <= '0;
      valid_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            log_hold   <= log_in_packed;
            sign_hold  <= sign_in_packed;
            valid_hold <= valid_in_packed;
            counter    <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          counter <= counter + 1'b1;
          if (counter == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          // Leave on the edge that registers out_last so a new vector can
          // be accepted during the out_last cycle.
          if (s1_valid && s1_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    term_log   = '0;
    term_sign  = 1'b0;
    term_valid = 1'b0;
    for (int k = 0; k < Q_ORD; k++) begin
      if (counter == IW'(k)) begin
        term_log   = log_hold[k*LOG_WIDTH +: LOG_WIDTH];
        term_sign  = sign_hold[k];
        term_valid = valid_hold[k];
      end
    end
    e_c     = term_log[LOG_WIDTH-1:FRAC_WIDTH];
    shift_c = SW'(e_c) + QP_S;
    sat_c   = (shift_c >= SAT_SHIFT);
    zero_c  = !term_valid || shift_c[SW-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_shift <= '0;
      s1_m     <= '0;
      s1_sign  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= (state == ISSUE);
      s1_shift <= shift_c;
      s1_m     <= {1'b1, term_log[FRAC_WIDTH-1:0]};
      s1_sign  <= term_sign;
      s1_sat   <= sat_c;
      s1_zero  <= zero_c;
      s1_idx   <= counter;
      s1_last  <= (counter == LAST_IDX);
    end
  end

  // Only shifts in 0..WIDTH-2 reach the shifter path, so the truncated
  // quotient always fits in WIDTH-1 bits and negation never overflows.
  always_comb begin
    sh_u = s1_shift;
    if (s1_zero)
      mag_c = '0;
    else if (s1_sat)
      mag_c = MAX_MAG;
    else
      mag_c = WIDTH'((PW'(s1_m) << sh_u) >> FRAC_WIDTH);
    data_c = s1_sign ? (~mag_c + 1'b1) : mag_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_data  <= s1_valid ? data_c : '0;
      out_idx   <= s1_valid ? s1_idx : '0;
      out_last  <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_antilog_unpack_pip.sv
module tb_antilog_unpack_pip;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [50:0] log_in_packed;
  logic [2:0]  sign_in_packed;
  logic [2:0]  valid_in_packed;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  antilog_unpack_pip dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .log_in_packed   (log_in_packed),
    .sign_in_packed  (sign_in_packed),
    .valid_in_packed (valid_in_packed),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_idx         (out_idx),
    .out_last        (out_last),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] lw(input int e, input int f);
    logic [4:0]  ev;
    logic [11:0] fv;
    ev = e[4:0];
    fv = f[11:0];
    return {ev, fv};
  endfunction

  // Offer a vector at a negedge, accept on the next posedge (E0), then check
  // every output cycle up to E0+5. With garbage=1, in_valid stays high with
  // other data during ISSUE/DRAIN and must be ignored.
  task automatic run_vec(input string name, input logic [16:0] l0, input logic [16:0] l1,
                         input logic [16:0] l2, input logic [2:0] sg, input logic [2:0] vl,
                         input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                         input bit garbage);
    logic [15:0] exp_d [3];
    exp_d[0] = x0; exp_d[1] = x1; exp_d[2] = x2;
    @(negedge clk);
    in_valid = 1'b1;
    log_in_packed = {l2, l1, l0};
    sign_in_packed = sg;
    valid_in_packed = vl;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s accept: busy=%b in_ready=%b required 1 0", name, busy, in_ready);
    end
    if (garbage) begin
      log_in_packed = {lw(3, 0), lw(3, 0), lw(3, 0)};
      sign_in_packed = 3'b111;
      valid_in_packed = 3'b111;
    end else begin
      in_valid = 1'b0;
      log_in_packed = '0;
      sign_in_packed = '0;
      valid_in_packed = '0;
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_d[c-2] || out_idx !== 2'(c-2)
            || out_last !== (c == 4)) begin
          n_err++;
          $display("FAIL %s term%0d: v=%b d=%0d idx=%0d last=%b required v=1 d=%0d idx=%0d last=%b",
                   name, c-2, out_valid, $signed(out_data), out_idx, out_last,
                   $signed(exp_d[c-2]), c-2, (c == 4));
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s idle_out c%0d: out_valid=%b required 0", name, c, out_valid);
        end
      end
      if (c <= 3) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s in_ready_busy c%0d: got %b required 0", name, c, in_ready);
        end
      end
      if (c == 3) in_valid = 1'b0;
      if (c == 4) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s in_ready_last: got %b required 1", name, in_ready);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_after: got %b required 0", name, busy);
        end
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s quiet c%0d: out_valid=%b busy=%b required 0 0", name, c, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    log_in_packed = '0;
    sign_in_packed = '0;
    valid_in_packed = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'd0 || out_idx !== 2'd0
        || out_last !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b v=%b d=%h idx=%0d last=%b busy=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    check_quiet("post_reset", 2);
  endtask

  task automatic test_basic();
    run_vec("basic", lw(0, 0), lw(0, 'h800), lw(-11, 'h800), 3'b010, 3'b111,
            16'd4096, -16'sd6144, 16'd3, 1'b0);
  endtask

  task automatic test_saturation();
    run_vec("sat", lw(3, 0), lw(3, 0), lw(2, 'hFFF), 3'b010, 3'b111,
            16'd32767, -16'sd32767, 16'd32764, 1'b0);
  endtask

  task automatic test_zero();
    run_vec("zero", lw(0, 'h123), lw(-13, 'hFFF), lw(-12, 0), 3'b001, 3'b110,
            16'd0, 16'd0, 16'd1, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_vec("ignore", lw(1, 0), lw(-1, 'h400), lw(0, 'hFFF), 3'b100, 3'b111,
            16'd8192, 16'd2560, -16'sd8191, 1'b1);
    check_quiet("ignore_after", 3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [6];
    logic [1:0]  exp_i [6];
    int          seen;
    int          slot [10];
    exp_d[0] = 16'd4096;  exp_d[1] = 16'd2048;  exp_d[2] = -16'sd4096;
    exp_d[3] = 16'd16384; exp_d[4] = 16'd0;     exp_d[5] = 16'd1024;
    for (int i = 0; i < 6; i++) exp_i[i] = 2'(i % 3);
    for (int c = 0; c < 10; c++) slot[c] = -1;
    slot[2] = 0; slot[3] = 1; slot[4] = 2; slot[7] = 3; slot[8] = 4; slot[9] = 5;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b1;
    log_in_packed = {lw(0, 0), lw(-1, 0), lw(0, 0)};
    sign_in_packed = 3'b100;
    valid_in_packed = 3'b111;
    @(posedge clk); #1;
    log_in_packed = {lw(-2, 0), lw(5, 0), lw(2, 0)};
    sign_in_packed = 3'b000;
    valid_in_packed = 3'b101;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b second_accept: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
      end
      if (slot[c] >= 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_d[slot[c]] || out_idx !== exp_i[slot[c]]) begin
          n_err++;
          $display("FAIL b2b out%0d: v=%b d=%0d idx=%0d required v=1 d=%0d idx=%0d",
                   slot[c], out_valid, $signed(out_data), out_idx,
                   $signed(exp_d[slot[c]]), exp_i[slot[c]]);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b gap c%0d: out_valid=%b required 0", c, out_valid);
        end
      end
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 6) begin
      n_err++;
      $display("FAIL b2b count: got %0d out_valid cycles required 6", seen);
    end
    check_quiet("b2b_after", 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    log_in_packed = {lw(0, 0), lw(0, 0), lw(0, 0)};
    sign_in_packed = 3'b000;
    valid_in_packed = 3'b111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid pre: out_valid=%b required 1", out_valid);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0
        || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid async: v=%b d=%h rdy=%b busy=%b last=%b required 0 0 1 0 0",
               out_valid, out_data, in_ready, busy, out_last);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_quiet("rst_mid_after", 4);
    run_vec("rst_fresh", lw(-3, 'h800), lw(4, 0), lw(1, 'h001), 3'b001, 3'b111,
            -16'sd768, 16'd32767, 16'd8194, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
